// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared state encoding and data width for the reg_sch write path
package reg_write_arbiter_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rtl/reg_write_arbiter_rr_pick.sv - combinational round-robin selector
// Searches upward from last+1 with wraparound; valid is low when no request is set.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] win,
  output logic          valid
);

  int idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!valid && req[idx]) begin
        win   = IW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write sequencer; sole driver of reg_sch LOAD/REG_IN
// Each write runs IDLE -> LOAD -> ACK, so at most one write completes every three cycles.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = DATA_W,
  parameter int CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  output logic [NREQ-1:0]    GNT,
  output logic [NREQ-1:0]    ACK,
  output logic               REG_LOAD,
  output logic [DW-1:0]      REG_DATA,
  output logic               BUSY,
  output logic [CNT_W-1:0]   WR_CNT
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t            state, state_nxt;
  logic [IW-1:0]     last, last_nxt;
  logic [IW-1:0]     sel, sel_nxt;
  logic [IW-1:0]     win;
  logic              win_vld;
  logic [NREQ-1:0]   gnt_nxt, ack_nxt;
  logic              load_nxt;
  logic [DW-1:0]     data_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req   (REQ),
    .last  (last),
    .win   (win),
    .valid (win_vld)
  );

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = sel;
    gnt_nxt   = GNT;
    ack_nxt   = '0;
    load_nxt  = 1'b0;
    data_nxt  = REG_DATA;
    cnt_nxt   = WR_CNT;
    case (state)
      ST_IDLE: begin
        if (win_vld) begin
          state_nxt = ST_LOAD;
          sel_nxt   = win;
          gnt_nxt   = ONE << win;
          data_nxt  = REQ_DATA[int'(win)*DW +: DW];
          load_nxt  = 1'b1;
        end
      end
      ST_LOAD: begin
        // reg_sch captures REG_DATA on this edge; the ACK follows regardless of REQ.
        state_nxt = ST_ACK;
        ack_nxt   = ONE << sel;
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        last_nxt  = sel;
        cnt_nxt   = (&WR_CNT) ? WR_CNT : WR_CNT + CNT_W'(1);
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      last     <= IW'(NREQ - 1);
      sel      <= '0;
      GNT      <= '0;
      ACK      <= '0;
      REG_LOAD <= 1'b0;
      REG_DATA <= '0;
      WR_CNT   <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      sel      <= sel_nxt;
      GNT      <= gnt_nxt;
      ACK      <= ack_nxt;
      REG_LOAD <= load_nxt;
      REG_DATA <= data_nxt;
      WR_CNT   <= cnt_nxt;
    end
  end

  assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - scoreboard bench for reg_write_arbiter with a reg_sch stand-in
module tb_reg_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ;
  logic [31:0] REQ_DATA;
  logic [3:0]  GNT, ACK;
  logic        REG_LOAD, BUSY;
  logic [7:0]  REG_DATA;
  logic [3:0]  WR_CNT;

  reg_write_arbiter #(.NREQ(4), .DW(8), .CNT_W(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .REQ_DATA (REQ_DATA),
    .GNT      (GNT),
    .ACK      (ACK),
    .REG_LOAD (REG_LOAD),
    .REG_DATA (REG_DATA),
    .BUSY     (BUSY),
    .WR_CNT   (WR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         w;
    logic [7:0] d;
    logic [3:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // requester and arbiter reference state
  int         m_busy, m_last, m_cur;
  logic [3:0] m_cnt;
  bit         active[4];
  int         hold_low[4];
  logic [7:0] reg_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reg_sch stand-in: loadable 8-bit register
  always @(posedge CLK or posedge RST) begin
    if (RST) reg_out <= 8'h00;
    else if (REG_LOAD) reg_out <= REG_DATA;
  end

  task automatic model_reset();
    exp_q.delete();
    m_busy = 0;
    m_last = 3;
    m_cur  = 0;
    m_cnt  = 4'd0;
  endtask

  // drive one cycle of requester behaviour, predict the arbiter's decision, advance a clock
  task automatic drive_cycle(input logic [3:0] want, input logic [31:0] dat, input bit rnd);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (hold_low[i] > 0) begin
        hold_low[i]--;
        active[i] = 1'b0;
      end else if (!active[i] && (want[i] || (rnd && $urandom_range(3) == 0))) begin
        active[i] = 1'b1;
        REQ_DATA[i*8 +: 8] = want[i] ? dat[i*8 +: 8] : 8'($urandom);
      end
    end
    if (rnd && m_busy == 2 && $urandom_range(3) == 0) begin
      active[m_cur]   = 1'b0;
      hold_low[m_cur] = 2;
      REQ_DATA[m_cur*8 +: 8] = 8'($urandom);
    end
    for (int i = 0; i < 4; i++) REQ[i] = active[i];
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        active[m_cur]   = 1'b0;
        hold_low[m_cur] = 1;
      end
    end else if (REQ != 4'b0) begin
      e.w = -1;
      for (int k = 1; k <= 4; k++)
        if (e.w < 0 && REQ[(m_last + k) % 4]) e.w = (m_last + k) % 4;
      e.d = REQ_DATA[e.w*8 +: 8];
      m_cnt = (m_cnt == 4'hF) ? m_cnt : m_cnt + 4'd1;
      e.c = m_cnt;
      exp_q.push_back(e);
      m_last = e.w;
      m_cur  = e.w;
      m_busy = 2;
    end
    @(posedge CLK);
    #1;
  endtask

  // monitor: pops an expectation whenever the DUT presents a load
  exp_t cur_e;
  bit   ack_pend = 1'b0;
  bit   cnt_pend = 1'b0;

  always @(negedge CLK) begin
    if (RST) begin
      ack_pend = 1'b0;
      cnt_pend = 1'b0;
    end else if (REG_LOAD) begin
      if (exp_q.size() == 0) begin
        check("unexpected_load", {31'd0, REG_LOAD}, 32'd0);
      end else begin
        cur_e = exp_q.pop_front();
        check("load_gnt", {28'd0, GNT}, 32'd1 << cur_e.w);
        check("load_data", {24'd0, REG_DATA}, {24'd0, cur_e.d});
        check("load_busy", {31'd0, BUSY}, 32'd1);
        ack_pend = 1'b1;
      end
      cnt_pend = 1'b0;
    end else if (ack_pend) begin
      check("ack_pulse", {28'd0, ACK}, 32'd1 << cur_e.w);
      check("ack_gnt", {28'd0, GNT}, 32'd1 << cur_e.w);
      ack_pend = 1'b0;
      cnt_pend = 1'b1;
    end else begin
      check("ack_idle", {28'd0, ACK}, 32'd0);
      if (cnt_pend) begin
        check("wr_cnt", {28'd0, WR_CNT}, {28'd0, cur_e.c});
        check("reg_out", {24'd0, reg_out}, {24'd0, cur_e.d});
        check("idle_gnt_busy", {27'd0, GNT, BUSY}, 32'd0);
        cnt_pend = 1'b0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      active[i]   = 1'b0;
      hold_low[i] = 0;
    end
    model_reset();
    RST      = 1'b1;
    REQ      = 4'hF;
    REQ_DATA = 32'hA5A5_A5A5;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check("reset_outs", {10'd0, GNT, ACK, REG_LOAD, REG_DATA, WR_CNT, BUSY}, 32'd0);
    end
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    REQ      = 4'h0;
    REQ_DATA = 32'h0;

    // single writer
    drive_cycle(4'b0001, 32'h0000_0001, 1'b0);
    for (int c = 0; c < 5; c++) drive_cycle(4'b0000, 32'h0, 1'b0);
    check("single_reg_out", {24'd0, reg_out}, 32'h01);

    // full contention
    drive_cycle(4'b1111, 32'h1312_1110, 1'b0);
    for (int c = 0; c < 14; c++) drive_cycle(4'b0000, 32'h0, 1'b0);

    // rotation: serve 2, then 3 must beat 1
    drive_cycle(4'b0100, 32'h0022_0000, 1'b0);
    for (int c = 0; c < 3; c++) drive_cycle(4'b0000, 32'h0, 1'b0);
    drive_cycle(4'b1010, 32'h3300_1100, 1'b0);
    for (int c = 0; c < 8; c++) drive_cycle(4'b0000, 32'h0, 1'b0);

    // abort during LOAD
    drive_cycle(4'b0001, 32'h0000_0055, 1'b0);
    check("abort_in_load", {31'd0, REG_LOAD}, 32'd1);
    RST = 1'b1;
    model_reset();
    #1;
    check("abort_clear", {10'd0, GNT, ACK, REG_LOAD, REG_DATA, WR_CNT, BUSY}, 32'd0);
    @(posedge CLK);
    #1;
    check("abort_no_ack", {28'd0, ACK}, 32'd0);
    RST = 1'b0;
    for (int c = 0; c < 5; c++) drive_cycle(4'b0000, 32'h0, 1'b0);
    check("abort_regrant_out", {24'd0, reg_out}, 32'h55);

    // random traffic, long enough to saturate the 4-bit counter
    for (int c = 0; c < 400; c++) drive_cycle(4'b0000, 32'h0, 1'b1);
    for (int c = 0; c < 6; c++) drive_cycle(4'b0000, 32'h0, 1'b0);
    check("sat_wr_cnt", {28'd0, WR_CNT}, 32'hF);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
